// File: rtl/maze_pkg.sv
// Shared constants for the maze tile renderer: map geometry, tile codes,
// palette, 8x8 1bpp tile bitmaps and the clear-sequencer state type.
package maze_pkg;

  localparam int MAP_W      = 40;
  localparam int MAP_H      = 30;
  localparam int MAP_SIZE   = MAP_W * MAP_H;
  localparam int TILE_SHIFT = 4;
  localparam int N_TILES    = 16;
  localparam int TILE_W     = $clog2(N_TILES);
  localparam int ADDR_W     = 11;

  typedef logic [TILE_W-1:0] tile_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  localparam tile_t TILE_EMPTY = 4'd0;
  localparam tile_t TILE_WALL  = 4'd1;
  localparam tile_t TILE_DOT   = 4'd2;

  localparam rgb_t PALETTE [N_TILES] = '{
    12'h000, 12'h00F, 12'hFB8, 12'hFFF, 12'hF8C, 12'hF00, 12'h0F0, 12'h0FF,
    12'hF0F, 12'hFF0, 12'h888, 12'h444, 12'hF80, 12'h08F, 12'h8F8, 12'hCCC
  };

  // Row-major bitmaps, eight rows per tile; bit 7 is the leftmost pixel.
  localparam logic [7:0] TILE_ROM [N_TILES*8] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'hFF, 8'h81, 8'hBD, 8'hA5, 8'hA5, 8'hBD, 8'h81, 8'hFF,
    8'h00, 8'h00, 8'h18, 8'h3C, 8'h3C, 8'h18, 8'h00, 8'h00,
    8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C,
    8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
    8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'hFF, 8'hFF, 8'hDB, 8'h99,
    8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'hFF, 8'hFF, 8'hDB, 8'h99,
    8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'hFF, 8'hFF, 8'hDB, 8'h99,
    8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'hFF, 8'hFF, 8'hDB, 8'h99,
    8'h3C, 8'h7E, 8'hF0, 8'hE0, 8'hE0, 8'hF0, 8'h7E, 8'h3C,
    8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55,
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h18, 8'h18, 8'h18, 8'h18,
    8'h18, 8'h18, 8'h18, 8'h18, 8'hFF, 8'h7E, 8'h3C, 8'h18,
    8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81,
    8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'h0F, 8'h0F
  };

endpackage

// File: rtl/tile_map_ram.sv
// Tile map storage: one write port, one registered read port, read-first on
// same-address collisions so it maps onto a single block RAM.
module tile_map_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11,
  parameter int DW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/maze_tile_renderer.sv
// Three-stage tile renderer behind the VGA timing generator, plus a write
// port and a clear sequencer for the tile map. Optional macro: GRID_OVERLAY_EN.
module maze_tile_renderer
  import maze_pkg::*;
(
  input  logic              pix_clk,
  input  logic              rst,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              display_enabled,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [TILE_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err,
  output logic [3:0]        R,
  output logic [3:0]        G,
  output logic [3:0]        B,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic              de_out
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  tile_t             ram_wdata;
  tile_t             tile_rd;
  logic              wr_in_range;
  logic              wr_err_q;

  logic [11:0]       lin_addr;
  logic [ADDR_W-1:0] s0_addr_d, s0_addr_q;
  logic [2:0]        s0_fx_q, s0_fy_q, s1_fx_q, s1_fy_q;
  logic              s0_de_q, s0_hs_q, s0_vs_q;
  logic              s1_de_q, s1_hs_q, s1_vs_q;
  logic [7:0]        rom_row;
  rgb_t              pix_rgb, rgb_q;
  logic              hs_out_q, vs_out_q, de_out_q;

`ifdef GRID_OVERLAY_EN
  localparam rgb_t GRID_RGB = 12'h333;
  logic s0_grid_d, s0_grid_q, s1_grid_q;
  assign s0_grid_d = (sx[3:0] == 4'd0) || (sy[3:0] == 4'd0);
`else
  logic unused_fine_lsb;
  assign unused_fine_lsb = sx[0] ^ sy[0];
`endif

  assign busy        = (state_q == ST_CLEAR);
  assign wr_ready    = ~busy & ~rst;
  assign wr_in_range = (wr_addr < ADDR_W'(MAP_SIZE));

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(MAP_SIZE - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A reset landing mid-clear must not zero the entry at the current pointer.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (busy && !rst) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr_q;
      ram_wdata = TILE_EMPTY;
    end else if (wr_en && wr_ready && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  tile_map_ram #(
    .DEPTH (MAP_SIZE),
    .AW    (ADDR_W),
    .DW    (TILE_W)
  ) u_tile_map_ram (
    .clk_i   (pix_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (s0_addr_q),
    .rdata_o (tile_rd)
  );

  assign lin_addr  = 12'(sy[9:TILE_SHIFT]) * 12'(MAP_W) + 12'(sx[9:TILE_SHIFT]);
  assign s0_addr_d = (display_enabled && (lin_addr < 12'(MAP_SIZE))) ?
                     lin_addr[ADDR_W-1:0] : '0;

  always_comb begin
    rom_row = TILE_ROM[{tile_rd, s1_fy_q}];
    pix_rgb = '0;
    if (s1_de_q && rom_row[3'd7 - s1_fx_q]) begin
      pix_rgb = PALETTE[tile_rd];
    end
`ifdef GRID_OVERLAY_EN
    if (s1_de_q && s1_grid_q) begin
      pix_rgb = GRID_RGB;
    end
`endif
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      s0_addr_q <= '0;
      s0_fx_q   <= '0;
      s0_fy_q   <= '0;
      s0_de_q   <= 1'b0;
      s0_hs_q   <= 1'b1;
      s0_vs_q   <= 1'b1;
      s1_fx_q   <= '0;
      s1_fy_q   <= '0;
      s1_de_q   <= 1'b0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      rgb_q     <= '0;
      hs_out_q  <= 1'b1;
      vs_out_q  <= 1'b1;
      de_out_q  <= 1'b0;
      wr_err_q  <= 1'b0;
`ifdef GRID_OVERLAY_EN
      s0_grid_q <= 1'b0;
      s1_grid_q <= 1'b0;
`endif
    end else begin
      s0_addr_q <= s0_addr_d;
      s0_fx_q   <= sx[3:1];
      s0_fy_q   <= sy[3:1];
      s0_de_q   <= display_enabled;
      s0_hs_q   <= h_sync_in;
      s0_vs_q   <= v_sync_in;
      s1_fx_q   <= s0_fx_q;
      s1_fy_q   <= s0_fy_q;
      s1_de_q   <= s0_de_q;
      s1_hs_q   <= s0_hs_q;
      s1_vs_q   <= s0_vs_q;
      rgb_q     <= pix_rgb;
      hs_out_q  <= s1_hs_q;
      vs_out_q  <= s1_vs_q;
      de_out_q  <= s1_de_q;
      wr_err_q  <= wr_en & wr_ready & ~wr_in_range;
`ifdef GRID_OVERLAY_EN
      s0_grid_q <= s0_grid_d;
      s1_grid_q <= s0_grid_q;
`endif
    end
  end

  assign R          = rgb_q.r;
  assign G          = rgb_q.g;
  assign B          = rgb_q.b;
  assign h_sync_out = hs_out_q;
  assign v_sync_out = vs_out_q;
  assign de_out     = de_out_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Self-checking bench: a tile-map model plus per-pixel arithmetic reference
// drives randomized and directed rendering, write-port and clear scenarios.
module tb_maze_tile_renderer;
  import maze_pkg::*;

  logic        pix_clk = 1'b0;
  logic        rst;
  logic [9:0]  sx, sy;
  logic        display_enabled, h_sync_in, v_sync_in;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ready, clr_req, busy, wr_err;
  logic [3:0]  R, G, B;
  logic        h_sync_out, v_sync_out, de_out;

  int tests = 0;
  int fails = 0;

  logic [3:0]  model_map [1200];
  logic [14:0] exp_q [$];
  logic [14:0] obs_q [$];

  maze_tile_renderer dut (
    .pix_clk(pix_clk), .rst(rst), .sx(sx), .sy(sy),
    .display_enabled(display_enabled), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .busy(busy), .wr_err(wr_err),
    .R(R), .G(G), .B(B),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .de_out(de_out)
  );

  always #5 pix_clk = ~pix_clk;

  // Expected output word {R,G,B,hs,vs,de} for one input pixel.
  function automatic logic [14:0] model_px(int x, int y, bit de, bit hs, bit vs);
    logic [11:0] rgb;
    logic [7:0]  bits;
    int          t;
    rgb = 12'h000;
    if (de) begin
      t    = int'(model_map[(y / 16) * 40 + (x / 16)]);
      bits = TILE_ROM[t * 8 + (y % 16) / 2];
      if (bits[7 - (x % 16) / 2]) rgb = PALETTE[t];
`ifdef GRID_OVERLAY_EN
      if ((x % 16) == 0 || (y % 16) == 0) rgb = 12'h333;
`endif
    end
    return {rgb, hs, vs, de};
  endfunction

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic idle_inputs();
    sx = '0; sy = '0; display_enabled = 1'b0;
    h_sync_in = 1'b1; v_sync_in = 1'b1;
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic write_tile(int addr, int data);
    wr_en = 1'b1; wr_addr = 11'(addr); wr_data = 4'(data);
    tick();
    wr_en = 1'b0;
    if (addr < 1200) model_map[addr] = 4'(data);
  endtask

  task automatic push_px(int x, int y, bit de, bit hs, bit vs);
    sx = 10'(x); sy = 10'(y); display_enabled = de; h_sync_in = hs; v_sync_in = vs;
    exp_q.push_back(model_px(x, y, de, hs, vs));
    tick();
    obs_q.push_back({R, G, B, h_sync_out, v_sync_out, de_out});
  endtask

  task automatic start_stream();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic flush();
    push_px(0, 0, 1'b0, 1'b1, 1'b1);
    push_px(0, 0, 1'b0, 1'b1, 1'b1);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    h_sync_in = 1'b0; v_sync_in = 1'b0;
    wr_addr = '0; wr_data = '0;
    tick(); tick();
    tests++; if ({R, G, B} !== 12'h000) begin fails++; $display("FAIL reset_rgb got=%h exp=000", {R, G, B}); end
    tests++; if ({h_sync_out, v_sync_out} !== 2'b11) begin fails++; $display("FAIL reset_sync got=%b exp=11", {h_sync_out, v_sync_out}); end
    tests++; if (de_out !== 1'b0) begin fails++; $display("FAIL reset_de got=%b exp=0", de_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
    rst = 1'b0;
    idle_inputs();
    #1;
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL release_wr_ready got=%b exp=1", wr_ready); end
    $display("[TB] reset checks done");
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    int ready_bad   = 0;
    for (int a = 0; a < 1200; a++) write_tile(a, TILE_WALL);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 1300 && busy === 1'b1; k++) begin
      busy_cycles++;
      if (wr_ready !== 1'b0) ready_bad++;
      clr_req = (k == 600);
      wr_en = (k == 100); wr_addr = 11'd7; wr_data = 4'd3;
      tick();
      clr_req = 1'b0; wr_en = 1'b0;
    end
    tests++; if (busy_cycles != 1200) begin fails++; $display("FAIL clear_busy_len got=%0d exp=1200", busy_cycles); end
    tests++; if (ready_bad != 0) begin fails++; $display("FAIL clear_wr_ready got=%0d high cycles exp=0", ready_bad); end
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL clear_done_ready got=%b exp=1", wr_ready); end
    for (int a = 0; a < 1200; a++) model_map[a] = TILE_EMPTY;
    start_stream();
    for (int a = 0; a < 1200; a++) push_px((a % 40) * 16, (a / 40) * 16, 1'b1, 1'b1, 1'b1);
    flush();
    for (int k = 0; k < exp_q.size() - 2; k++) begin
      tests++;
      if (obs_q[k+2] !== exp_q[k]) begin fails++; $display("FAIL clear_px tile=%0d got=%h exp=%h", k, obs_q[k+2], exp_q[k]); end
    end
    $display("[TB] clear: busy for %0d cycles, map rendered", busy_cycles);
  endtask

  task automatic test_latency();
    write_tile(0, TILE_WALL);
    tick(); tick(); tick();
    start_stream();
    for (int i = 0; i < 16; i++) push_px(i, 0, 1'b1, (i != 5), 1'b1);
    for (int i = 0; i < 16; i++) push_px(i, 2, 1'b1, 1'b1, 1'b1);
    flush();
    for (int k = 0; k < exp_q.size() - 2; k++) begin
      tests++;
      if (obs_q[k+2] !== exp_q[k]) begin fails++; $display("FAIL latency_px k=%0d got=%h exp=%h", k, obs_q[k+2], exp_q[k]); end
    end
    tests++; if (obs_q[1][0] !== 1'b0) begin fails++; $display("FAIL latency_early_de got=%b exp=0", obs_q[1][0]); end
    tests++; if (obs_q[2][14:3] !== 12'h00F) begin fails++; $display("FAIL latency_first_rgb got=%h exp=00F", obs_q[2][14:3]); end
    tests++; if ({obs_q[6][2], obs_q[7][2], obs_q[8][2]} !== 3'b101) begin
      fails++; $display("FAIL latency_hsync got=%b exp=101", {obs_q[6][2], obs_q[7][2], obs_q[8][2]});
    end
    tests++; if (obs_q[20][14:3] !== 12'h000) begin fails++; $display("FAIL latency_bitsel got=%h exp=000", obs_q[20][14:3]); end
    $display("[TB] latency: %0d pixels streamed", exp_q.size());
  endtask

  task automatic test_addressing();
    write_tile(1199, TILE_DOT);
    tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL addr_valid_err got=%b exp=0", wr_err); end
    wr_en = 1'b1; wr_addr = 11'd1200; wr_data = 4'd5;
    #1;
    tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL addr_err_early got=%b exp=0", wr_err); end
    tick();
    wr_en = 1'b0;
    tests++; if (wr_err !== 1'b1) begin fails++; $display("FAIL addr_err_pulse got=%b exp=1", wr_err); end
    tick();
    tests++; if (wr_err !== 1'b0) begin fails++; $display("FAIL addr_err_width got=%b exp=0", wr_err); end
    start_stream();
    push_px(632, 472, 1'b1, 1'b1, 1'b1);
    push_px(639, 479, 1'b1, 1'b1, 1'b1);
    push_px(624, 472, 1'b1, 1'b1, 1'b1);
    push_px(632, 472, 1'b0, 1'b0, 1'b1);
    flush();
    for (int k = 0; k < exp_q.size() - 2; k++) begin
      tests++;
      if (obs_q[k+2] !== exp_q[k]) begin fails++; $display("FAIL addr_px k=%0d got=%h exp=%h", k, obs_q[k+2], exp_q[k]); end
    end
    tests++; if (obs_q[2][14:3] !== 12'hFB8) begin fails++; $display("FAIL addr_last_tile got=%h exp=FB8", obs_q[2][14:3]); end
    $display("[TB] addressing: last tile and out-of-range write checked");
  endtask

  task automatic test_collision();
    write_tile(41, TILE_EMPTY);
    tick(); tick(); tick();
    start_stream();
    push_px(16, 16, 1'b1, 1'b1, 1'b1);
    model_map[41] = TILE_WALL;
    wr_en = 1'b1; wr_addr = 11'd41; wr_data = TILE_WALL;
    push_px(16, 16, 1'b1, 1'b1, 1'b1);
    wr_en = 1'b0;
    push_px(16, 16, 1'b1, 1'b1, 1'b1);
    flush();
    for (int k = 0; k < exp_q.size() - 2; k++) begin
      tests++;
      if (obs_q[k+2] !== exp_q[k]) begin fails++; $display("FAIL collide_px k=%0d got=%h exp=%h", k, obs_q[k+2], exp_q[k]); end
    end
    tests++; if (obs_q[2][14:3] !== 12'h000) begin fails++; $display("FAIL collide_old got=%h exp=000", obs_q[2][14:3]); end
    tests++; if (obs_q[4][14:3] !== 12'h00F) begin fails++; $display("FAIL collide_new got=%h exp=00F", obs_q[4][14:3]); end
    $display("[TB] read-first collision checked");
  endtask

  task automatic test_back_to_back();
    int x, y;
    bit de;
    for (int i = 0; i < 60; i++) write_tile($urandom_range(0, 1199), $urandom_range(0, 15));
    start_stream();
    for (int i = 0; i < 400; i++) begin
      de = ($urandom_range(0, 3) != 0);
      if (de) begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
      else    begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
      push_px(x, y, de, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
    end
    flush();
    for (int k = 0; k < exp_q.size() - 2; k++) begin
      tests++;
      if (obs_q[k+2] !== exp_q[k]) begin fails++; $display("FAIL random_px k=%0d got=%h exp=%h", k, obs_q[k+2], exp_q[k]); end
    end
    $display("[TB] back-to-back: %0d random pixels", exp_q.size() - 2);
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < 1200; a++) write_tile(a, TILE_WALL);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midclr_busy_start got=%b exp=1", busy); end
    for (int k = 1; k <= 300; k++) tick();
    rst = 1'b1;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midclr_busy_abort got=%b exp=0", busy); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL midclr_ready_rst got=%b exp=0", wr_ready); end
    rst = 1'b0;
    for (int a = 0; a < 300; a++) model_map[a] = TILE_EMPTY;
    start_stream();
    for (int a = 0; a < 1200; a++) push_px((a % 40) * 16, (a / 40) * 16, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) push_px(640 + i * 5, 4800 / (i + 10), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) push_px(i * 30, 300 + i, 1'b0, 1'b0, 1'b1);
    flush();
    for (int k = 0; k < exp_q.size() - 2; k++) begin
      tests++;
      if (obs_q[k+2] !== exp_q[k]) begin fails++; $display("FAIL midclr_px k=%0d got=%h exp=%h", k, obs_q[k+2], exp_q[k]); end
    end
    tests++; if (obs_q[301][14:3] !== 12'h000) begin fails++; $display("FAIL midclr_addr299 got=%h exp=000", obs_q[301][14:3]); end
    tests++; if (obs_q[302][14:3] !== 12'h00F) begin fails++; $display("FAIL midclr_addr300 got=%h exp=00F", obs_q[302][14:3]); end
    $display("[TB] reset mid-clear: partial map checked");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_latency();
    test_addressing();
    test_collision();
    test_back_to_back();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
